// File: rtl/riscy_pkg.sv
// Shared definitions for the decode stage and the alu: control encodings and
// the opcode/funct fields of the supported RV32 ALU subset.
package riscy_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // I-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, synchronous clear; x0 always reads as zero.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rd_addr1,
    output logic [XLEN-1:0] rd_data1,
    input  logic [4:0]      rd_addr2,
    output logic [XLEN-1:0] rd_data2,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_r [NREGS];

    // Register array update: clear on reset, otherwise write any non-x0 target
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (wr_addr != 5'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == 5'd0) ? {XLEN{1'b0}} : regs_r[rd_addr1];
    assign rd_data2 = (rd_addr2 == 5'd0) ? {XLEN{1'b0}} : regs_r[rd_addr2];

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: decodes the RV32 ALU subset, reads the register
// file with writeback bypass, and holds operands in a valid/ready ID/EX register.
module decode_stage
    import riscy_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [2:0]      ex_ctrl,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_rd_we,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic            dec_legal_s;
    logic            dec_is_r_s;
    alu_ctrl_e       dec_ctrl_s;
    logic [XLEN-1:0] rf_rd1_s;
    logic [XLEN-1:0] rf_rd2_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic            accept_s;
    logic [4:0]      held_rs1_r;
    logic [4:0]      held_rs2_r;
    logic            held_is_r_r;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign funct7_s = instr[31:25];

    assign instr_ready = !ex_valid || ex_ready;
    assign accept_s    = instr_valid && instr_ready;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rs1_s),
        .rd_data1 (rf_rd1_s),
        .rd_addr2 (rs2_s),
        .rd_data2 (rf_rd2_s),
        .we       (wb_we),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    // Instruction decoder for the supported R-type and I-type ALU subset
    always_comb begin
        dec_legal_s = 1'b0;
        dec_is_r_s  = 1'b0;
        dec_ctrl_s  = ADD;
        case (opcode_s)
            OPC_OP: begin
                dec_is_r_s = 1'b1;
                if (funct7_s == F7_BASE) begin
                    case (funct3_s)
                        F3_ADD:  begin dec_legal_s = 1'b1; dec_ctrl_s = ADD; end
                        F3_AND:  begin dec_legal_s = 1'b1; dec_ctrl_s = AND; end
                        F3_OR:   begin dec_legal_s = 1'b1; dec_ctrl_s = OR;  end
                        F3_SLT:  begin dec_legal_s = 1'b1; dec_ctrl_s = SLT; end
                        default: dec_legal_s = 1'b0;
                    endcase
                end else if ((funct7_s == F7_SUB) && (funct3_s == F3_ADD)) begin
                    dec_legal_s = 1'b1;
                    dec_ctrl_s  = SUB;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OPC_OPIMM: begin
                case (funct3_s)
                    F3_ADD:  begin dec_legal_s = 1'b1; dec_ctrl_s = ADD; end
                    F3_AND:  begin dec_legal_s = 1'b1; dec_ctrl_s = AND; end
                    F3_OR:   begin dec_legal_s = 1'b1; dec_ctrl_s = OR;  end
                    F3_SLT:  begin dec_legal_s = 1'b1; dec_ctrl_s = SLT; end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Operand selection: a same-cycle writeback to a source bypasses the array
    always_comb begin
        if (wb_we && (wb_addr == rs1_s) && (rs1_s != 5'd0)) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = rf_rd1_s;
        end
        if (!dec_is_r_s) begin
            op_b_s = imm_i(instr);
        end else if (wb_we && (wb_addr == rs2_s) && (rs2_s != 5'd0)) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = rf_rd2_s;
        end
    end

    // ID/EX register: load on legal accept, drop on retire, refresh held operands while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs1      <= {XLEN{1'b0}};
            ex_rs2      <= {XLEN{1'b0}};
            ex_ctrl     <= 3'b000;
            ex_rd_addr  <= 5'd0;
            ex_rd_we    <= 1'b0;
            illegal     <= 1'b0;
            held_rs1_r  <= 5'd0;
            held_rs2_r  <= 5'd0;
            held_is_r_r <= 1'b0;
        end else begin
            illegal <= accept_s && !dec_legal_s;
            if (accept_s && dec_legal_s) begin
                ex_valid    <= 1'b1;
                ex_rs1      <= op_a_s;
                ex_rs2      <= op_b_s;
                ex_ctrl     <= dec_ctrl_s;
                ex_rd_addr  <= rd_s;
                ex_rd_we    <= (rd_s != 5'd0);
                held_rs1_r  <= rs1_s;
                held_rs2_r  <= rs2_s;
                held_is_r_r <= dec_is_r_s;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end else if (ex_valid && wb_we && (wb_addr != 5'd0)) begin
                if (wb_addr == held_rs1_r) begin
                    ex_rs1 <= wb_data;
                end
                if (held_is_r_r && (wb_addr == held_rs2_r)) begin
                    ex_rs2 <= wb_data;
                end
            end
        end
    end

endmodule
